// File: rtl/kalman_mul_arbiter_pkg.sv
// Shared Q-format constants for the Kalman datapath: default widths and the
// saturation limits that follow from them.
package kalman_mul_arbiter_pkg;

    localparam int Q_DATA_W  = 16;
    localparam int Q_FRAC_W  = 8;
    localparam int Q_N_REQ   = 4;
    localparam int Q_MUL_LAT = 3;

    localparam logic signed [Q_DATA_W-1:0] Q_SAT_MAX = {1'b0, {(Q_DATA_W-1){1'b1}}};
    localparam logic signed [Q_DATA_W-1:0] Q_SAT_MIN = {1'b1, {(Q_DATA_W-1){1'b0}}};

endpackage

// File: rtl/kalman_mul_arbiter_if.sv
// Request/response bundle between the Kalman stage engines (master) and the
// shared multiplier arbiter (slave).
interface kalman_mul_arbiter_if
    import kalman_mul_arbiter_pkg::*;
#(
    parameter int N_REQ  = Q_N_REQ,
    parameter int DATA_W = Q_DATA_W
);
    logic                      en;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*DATA_W-1:0]   req_a;
    logic [N_REQ*DATA_W-1:0]   req_b;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    modport master (
        output en, req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  en, req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/kalman_fxp_mul.sv
// MUL_LAT-stage signed fixed-point multiply with round-half-up and saturation;
// a valid bit and a one-hot tag travel alongside each operation.
module kalman_fxp_mul
    import kalman_mul_arbiter_pkg::*;
#(
    parameter int DATA_W  = Q_DATA_W,
    parameter int FRAC_W  = Q_FRAC_W,
    parameter int MUL_LAT = Q_MUL_LAT,
    parameter int TAG_W   = Q_N_REQ
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     op_vld,
    input  logic [TAG_W-1:0]         op_tag,
    input  logic signed [DATA_W-1:0] op_a,
    input  logic signed [DATA_W-1:0] op_b,
    output logic                     res_vld,
    output logic [TAG_W-1:0]         res_tag,
    output logic signed [DATA_W-1:0] res_data,
    output logic                     busy
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [PROD_W:0] HALF   = {{(PROD_W-FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [PROD_W:0] SAT_HI = {{(PROD_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W:0] SAT_LO = {{(PROD_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    // One guard bit so adding the rounding constant can never wrap.
    function automatic logic signed [PROD_W:0] round_shift(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] r;
        r = {p[PROD_W-1], p} + HALF;
        return r >>> FRAC_W;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PROD_W:0] s);
        if (s > SAT_HI)
            return SAT_HI[DATA_W-1:0];
        else if (s < SAT_LO)
            return SAT_LO[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0] a_p0, b_p0;
    logic signed [PROD_W-1:0] prod_p0;
    logic                     vld_p [MUL_LAT];
    logic [TAG_W-1:0]         tag_p [MUL_LAT];
    logic signed [DATA_W-1:0] res_p [1:MUL_LAT-1];

    // Stage 0: operand capture at the transfer edge
    always_ff @(posedge clk) begin
        a_p0 <= op_a;
        b_p0 <= op_b;
    end

    assign prod_p0 = a_p0 * b_p0;

    // Stage 1..MUL_LAT-1: rounded/saturated result, then a plain delay line.
    // Results are cleared too so rsp_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                vld_p[k] <= 1'b0;
                tag_p[k] <= '0;
            end
            for (int k = 1; k < MUL_LAT; k++)
                res_p[k] <= '0;
        end else begin
            vld_p[0] <= op_vld;
            tag_p[0] <= op_vld ? op_tag : '0;
            res_p[1] <= saturate(round_shift(prod_p0));
            for (int k = 1; k < MUL_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                tag_p[k] <= tag_p[k-1];
            end
            for (int k = 2; k < MUL_LAT; k++)
                res_p[k] <= res_p[k-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < MUL_LAT; k++)
            busy = busy | vld_p[k];
    end

    assign res_vld  = vld_p[MUL_LAT-1];
    assign res_tag  = tag_p[MUL_LAT-1];
    assign res_data = res_p[MUL_LAT-1];
endmodule

// File: rtl/kalman_mul_arbiter.sv
// Round-robin arbiter in front of one shared pipelined multiplier; results
// return to the granted requester as a one-hot strobe after MUL_LAT cycles.
module kalman_mul_arbiter
    import kalman_mul_arbiter_pkg::*;
#(
    parameter int N_REQ   = Q_N_REQ,
    parameter int DATA_W  = Q_DATA_W,
    parameter int FRAC_W  = Q_FRAC_W,
    parameter int MUL_LAT = Q_MUL_LAT
)(
    input  logic               clk,
    input  logic               reset_n,
    kalman_mul_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]         last;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W-1:0]         idx;
    logic [N_REQ-1:0]         grant;
    logic                     found;
    logic signed [DATA_W-1:0] a_sel, b_sel;
    logic                     res_vld;
    logic [N_REQ-1:0]         res_tag;
    logic signed [DATA_W-1:0] res_data;
    logic                     busy;

    // Scan from last+1 around to last; reset_n gates grants so ready is low during reset.
    always_comb begin
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % N_REQ);
            if (bus.en && reset_n && !found && bus.req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                a_sel = bus.req_a[i*DATA_W +: DATA_W];
                b_sel = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last <= IDX_W'(N_REQ - 1);
        else if (found)
            last <= grant_idx;
    end

    kalman_fxp_mul #(
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .MUL_LAT (MUL_LAT),
        .TAG_W   (N_REQ)
    ) u_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_vld   (found),
        .op_tag   (grant),
        .op_a     (a_sel),
        .op_b     (b_sel),
        .res_vld  (res_vld),
        .res_tag  (res_tag),
        .res_data (res_data),
        .busy     (busy)
    );

    assign bus.req_ready = grant;
    assign bus.rsp_valid = res_vld ? res_tag : '0;
    assign bus.rsp_data  = res_data;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_kalman_mul_arbiter.sv
// Directed bench for kalman_mul_arbiter: scoreboard of expected products keyed
// by issue cycle, compared against one-hot responses.
module tb_kalman_mul_arbiter;
    import kalman_mul_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int F   = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    kalman_mul_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    kalman_mul_arbiter #(
        .N_REQ(N), .DATA_W(W), .FRAC_W(F), .MUL_LAT(LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        int           issue;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] op_a_tab [6] = '{16'h7F00, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'hFFFF};
    logic [15:0] op_b_tab [6] = '{16'h0200, 16'h0200, 16'h8000, 16'h0080, 16'h007F, 16'h0080};
    logic [15:0] exp_tab  [6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, r;
        p = longint'($signed(a)) * longint'($signed(b));
        r = (p + (longint'(1) << (F - 1))) >>> F;
        if (r > Q_SAT_MAX)
            r = Q_SAT_MAX;
        else if (r < Q_SAT_MIN)
            r = Q_SAT_MIN;
        return r[W-1:0];
    endfunction

    // Responses are checked first, then this cycle's transfer is recorded.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (bus.rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.idx);
                    check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    check("rsp_latency", 32'(cyc - e.issue), 32'(LAT));
                end
            end else if (sb.size() > 0 && (cyc - sb[0].issue) > LAT) begin
                check("rsp_missing", 32'(cyc - sb[0].issue), 32'(LAT));
                void'(sb.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i])
                    sb.push_back('{idx: i, data: model(bus.req_a[i*W +: W], bus.req_b[i*W +: W]), issue: cyc});
            end
        end
    end

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b);
        int waited = 0;
        @(posedge clk);
        #1;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
        @(negedge clk);
        while (!bus.req_ready[i] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("grant_wait", 32'(bus.req_ready[i]), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
    endtask

    initial begin
        int waited;
        reset_n       = 1'b0;
        bus.en        = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.en        = 1'b1;
        bus.req_valid = '1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single requester, 1.5 * 2.0
        issue(1, 16'h0180, 16'h0200);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("single_busy", 32'(bus.busy), 32'd1);
            if (k == LAT - 1) begin
                check("single_rsp_valid", 32'(bus.rsp_valid), 32'h2);
                check("single_rsp_data",  32'(bus.rsp_data),  32'h0300);
            end
        end
        @(negedge clk);
        check("single_busy_fall", 32'(bus.busy), 32'd0);

        // Saturation and rounding corners
        for (int k = 0; k < 6; k++) begin
            issue(2, op_a_tab[k], op_b_tab[k]);
            repeat (LAT) @(negedge clk);
            check("sat_round_valid", 32'(bus.rsp_valid), 32'h4);
            check("sat_round_data",  32'(bus.rsp_data),  32'(exp_tab[k]));
        end

        // Round-robin with all requesters holding valid out of reset
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = 16'(16'h0100 * (i + 1) + i);
            bus.req_b[i*W +: W] = 16'(16'h0180 - 16'h0040 * i);
        end
        bus.req_valid = '1;
        bus.en        = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(bus.req_ready), 32'(1) << (k % N));
        end

        // Enable gating with a full pipeline
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        #1;
        check("en0_req_ready", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("en0_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check("en0_busy_fall", 32'(bus.busy), 32'd0);
        check("en0_drained", 32'(sb.size()), 32'd0);

        // Reset with ops in flight
        @(posedge clk);
        #1;
        bus.en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        sb.delete();
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("postrst_quiet", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '1;
        #1;
        check("postrst_first_grant", 32'(bus.req_ready), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = '0;

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kalman_mul_arbiter.md
# kalman_mul_arbiter

Shared fixed-point multiplier with round-robin arbitration for the Kalman core. The predict, gain and update stages present independent multiply requests. This block grants one request per cycle to a single pipelined signed multiplier, then returns the rounded and saturated product to the originating requester after a fixed latency. It sits between the Kalman sequencing FSM's stage engines and the multiplier hardware, so the design needs only one DSP-mapped multiplier.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand/result width, signed two's complement
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
- MUL_LAT, 3, issue-to-result latency in cycles (>=2)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  arbitration enable; 0 blocks new grants
- req_valid  in  N_REQ  per-requester request
- req_a  in  N_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  N_REQ*DATA_W  operand B, same packing
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rsp_valid  out  N_REQ  one-hot result strobe, 1 cycle
- rsp_data  out  DATA_W  product, valid while any rsp_valid bit is set
- busy  out  1  any pipeline stage holds a valid op

## Operation
- Arbiter: round-robin pointer `last` (index of the last grant).
  - Priority order is last+1, last+2, …, wrapping modulo N_REQ.
  - req_ready is combinational: one-hot on the first valid requester in priority order, only when en=1; otherwise all zero.
  - On a transfer, `last` takes the granted index at the next edge. With no transfer, `last` holds.
- Requester rules:
  - Hold req_valid, req_a and req_b stable until it sees ready.
  - Must not drop req_valid before ready.
  - May issue back-to-back; a lone requester is granted every cycle.
- Pipeline: MUL_LAT stages, each carrying a valid bit, a grant index and the data.
  - No backpressure: every requester must accept rsp_valid whenever it is strobed.
- Arithmetic, applied in order:
  1. Full product p = a*b, 2*DATA_W bits, signed.
  2. Round half-up: add 2^(FRAC_W-1).
  3. Arithmetic shift right by FRAC_W.
  4. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- en=0: in-flight ops continue and their results are still delivered; busy reflects the drain.
- Reset (async assert, sync deassert handled upstream) drives the following, regardless of mid-operation state:
  - `last` = N_REQ-1, so requester 0 has first priority.
  - All pipeline valid bits = 0.
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - In-flight ops are discarded; no stale result appears after release.

## Timing
- An op transferred at edge t produces a result that is valid during the cycle after edge t+MUL_LAT-1. Latency is exactly MUL_LAT cycles.
- Throughput: 1 op/cycle aggregate.
- Starvation bound: with all N_REQ requesting, any requester waits at most N_REQ-1 cycles.
- Simultaneous events:
  - Issue and retire in the same cycle are independent.
  - rsp_valid is never more than one-hot, because one op is issued per cycle.
- Combinational path: req_valid → req_ready only. rsp_valid, rsp_data and busy are registered.

## Structure
- The shared Kalman package holds the Q-format constants: DATA_W and FRAC_W defaults, plus the saturation limits derived from them.
- Sub-module kalman_fxp_mul holds the MUL_LAT-stage signed multiply, rounding and saturation, with a valid/tag sideband.
- The arbiter, pointer, operand mux and response demux stay in kalman_mul_arbiter.

## Test plan
- Single requester:
  - Stimulus: req 1 issues a=0x0180, b=0x0200 (1.5*2.0).
  - Required: rsp_valid=0b0010 and rsp_data=0x0300 exactly 3 cycles after the transfer; busy high 3 cycles.
- Round-robin:
  - Stimulus: all 4 requesters hold req_valid from reset.
  - Required: grant order 0,1,2,3,0,1…; each rsp_valid matches its issue index 3 cycles later.
- Saturation:
  - 0x7F00*0x0200 → 0x7FFF.
  - 0x8000*0x0200 → 0x8000.
  - 0x8000*0x8000 → 0x7FFF.
- Rounding:
  - 0x0001*0x0080 → 0x0001.
  - 0x0001*0x007F → 0x0000.
  - 0xFFFF*0x0080 → 0x0000 (the -0.5 LSB case rounds up).
- Enable gating:
  - Stimulus: pipeline full, then en=0 with all requesting.
  - Required: req_ready=0; the 3 in-flight results are still delivered; busy falls 3 cycles after the last issue.
- Reset mid-operation:
  - Stimulus: pulse reset_n low with 3 ops in flight.
  - Required: all outputs 0 immediately; after release, no rsp_valid until a new transfer; first grant goes to requester 0.
